mux16_rr_arbiter: RTL and testbench
===================================

# mux16_rr_arbiter

Round-robin arbiter that shares the 16-to-1 multiplexer between 16 requesters. It picks one requester at a time and drives the multiplexer select from a register. The select is held stable while the owner is served, and ownership moves in fair rotation. The block sits directly in front of the `sel` input of the existing structural 16:1 mux; the mux datapath itself is outside this block.

## Interface
- `MAX_HOLD`, 8'd16: maximum cycles one requester may hold the grant. 0 = no timeout. Legal range 0..255.
- `clk`  in  1  rising-edge clock, only clock of the block.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  16  per-requester request, level-sensitive; bit i = requester i.
- `done`  in  1  owner release strobe, one cycle, sampled only in BUSY.
- `sel`  out  4  registered mux select; index of the current/last owner.
- `grant`  out  16  registered one-hot grant; all-zero when no owner.
- `valid`  out  1  registered; 1 while `grant` is non-zero; `sel` is meaningful to the mux only then.
- `timeout`  out  1  registered one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- State machine: IDLE, BUSY, encoded 1 bit.
- Internal registers:
  - `ptr[3:0]`: next priority start.
  - `hold_cnt[7:0]`: cycles in BUSY.
- **IDLE**
  - If `req` != 0: choose the lowest index i, searching `ptr`, `ptr+1`, …, wrapping 15→0.
  - Register `sel`=i, `grant`=1<<i, `valid`=1, clear `hold_cnt`, go to BUSY.
  - If `req`==0: stay in IDLE; outputs unchanged except `grant`=0 and `valid`=0. `sel` keeps its last value.
- **BUSY**
  - Release condition: `req[sel]`==0, or `done`==1, or (`MAX_HOLD`!=0 and `hold_cnt`==`MAX_HOLD`-1).
  - On release:
    - `grant`=0, `valid`=0.
    - `ptr`=`sel`+1 mod 16 (15 wraps to 0).
    - Go to IDLE.
    - `timeout`=1 only if the hold limit alone caused the release, i.e. `req[sel]`=1 and `done`=0.
  - Otherwise `hold_cnt` increments, saturating at 255, and all outputs hold.
- Changes to `req` bits other than the owner's are ignored in BUSY.
- Simultaneous `done` and owner `req` drop: one release, no `timeout`.
- Reset, from any state including mid-grant:
  - IDLE, `ptr`=0, `hold_cnt`=0.
  - `sel`=4'd0, `grant`=16'd0, `valid`=0, `timeout`=0.
  - Takes effect on the first rising edge with `rst`=1.

## Timing
- Grant latency: `req` sampled high at edge N in IDLE → `grant`/`sel`/`valid` valid after edge N.
- Release: condition sampled at edge M → `grant`=0 after edge M.
- Re-arbitration happens at edge M+1, so there is exactly one idle cycle between owners. This gives the mux select a clean settle cycle.
- `sel` changes only on a grant edge, never during BUSY or on release. The mux output for the owner is stable for the whole grant.
- Maximum grant length with `MAX_HOLD`=K (K≥1): K cycles with `valid`=1.
- Worst-case wait for a continuously requesting, never-releasing population with `MAX_HOLD`=K: 15·(K+1) cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/header holds:
  - `N_REQ`=16, `SEL_W`=4.
  - State encodings `ST_IDLE`=1'b0, `ST_BUSY`=1'b1.
  - The `MAX_HOLD` default.
- Sub-module `rr_pick16`: purely combinational.
  - Inputs `req[15:0]`, `ptr[3:0]`.
  - Outputs `any`, `idx[3:0]`.
  - Implemented as rotate-right by `ptr`, fixed-priority encode, add `ptr` back mod 16.
- Top level holds the FSM, counters and output registers.

## Test plan
- **Reset:** hold `rst` 2 cycles with `req`=16'hFFFF → `grant`=0, `valid`=0, `sel`=0. Release `rst` → next edge gives `grant`=16'h0001, `sel`=0.
- **Rotation:** `req`=16'hFFFF, `done` pulsed 1 cycle after every grant → `sel` sequence 0,1,2,…,15,0. Each grant is separated by one `valid`=0 cycle.
- **Wrap and skip:** `ptr`=14 (after serving 13), `req`=16'h0011 → grant `sel`=0. Then after release → `sel`=4.
- **Timeout:** `MAX_HOLD`=4, `req`=16'h0008 held, no `done` → `valid`=1 for exactly 4 cycles, `timeout` pulses once, then after one gap requester 3 is re-granted.
- **Owner drop vs. other activity:** owner 5 in BUSY while `req[9]` toggles → no change. Then drop `req[5]` in the same cycle as `done`=1 → single release, `timeout`=0, next `sel`=9.
- **Mid-grant reset:** `rst` asserted during BUSY with `sel`=7 → all outputs reset the next edge, and arbitration restarts from requester 0.

Source files
------------

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 16-way round-robin mux-select arbiter.
package mux16_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  localparam logic [7:0] MAX_HOLD_DEF = 8'd16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: lowest set request at or after i_ptr, wrapping 15 -> 0.
module rr_pick16
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_any,
  output logic [SEL_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  always_comb begin
    // Rotate right by ptr so that requester ptr lands on bit 0.
    w_rot = N_REQ'({i_req, i_req} >> i_ptr);
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = SEL_W'(i);
      end
    end
    o_any = |i_req;
    o_idx = w_off + i_ptr;
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a 16:1 mux; select is held for the whole grant
// and one idle cycle separates consecutive owners.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter logic [7:0] MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_done,
  output logic [SEL_W-1:0] o_sel,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_valid,
  output logic             o_timeout
);

  state_e           r_state, w_state_n;
  logic [SEL_W-1:0] r_ptr, w_ptr_n;
  logic [7:0]       r_hold_cnt, w_hold_cnt_n;
  logic [SEL_W-1:0] r_sel, w_sel_n;
  logic [N_REQ-1:0] r_grant, w_grant_n;
  logic             r_valid, w_valid_n;
  logic             r_timeout, w_timeout_n;

  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_owner_req;
  logic             w_hold_hit;
  logic             w_release;

  rr_pick16 u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_owner_req = i_req[r_sel];
  assign w_hold_hit  = (MAX_HOLD != 8'd0) && (r_hold_cnt == MAX_HOLD - 8'd1);
  assign w_release   = !w_owner_req || i_done || w_hold_hit;

  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_hold_cnt_n = r_hold_cnt;
    w_sel_n      = r_sel;
    w_grant_n    = r_grant;
    w_valid_n    = r_valid;
    w_timeout_n  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_grant_n = '0;
        w_valid_n = 1'b0;
        if (w_any) begin
          w_sel_n          = w_idx;
          w_grant_n[w_idx] = 1'b1;
          w_valid_n        = 1'b1;
          w_hold_cnt_n     = 8'd0;
          w_state_n        = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_grant_n = '0;
          w_valid_n = 1'b0;
          w_ptr_n   = r_sel + SEL_W'(1);
          w_state_n = ST_IDLE;
          // Flag a timeout only when the hold limit was the sole cause.
          w_timeout_n = w_owner_req && !i_done;
        end else if (r_hold_cnt != 8'hFF) begin
          w_hold_cnt_n = r_hold_cnt + 8'd1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= 8'd0;
      r_sel      <= '0;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_hold_cnt <= w_hold_cnt_n;
      r_sel      <= w_sel_n;
      r_grant    <= w_grant_n;
      r_valid    <= w_valid_n;
      r_timeout  <= w_timeout_n;
    end
  end

  assign o_sel     = r_sel;
  assign o_grant   = r_grant;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/timeouts, a negedge monitor checks them.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  int grant_q[$];
  int to_q[$];
  logic prev_valid = 1'b0;

  mux16_rr_arbiter #(
    .MAX_HOLD (8'd4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_done    (done),
    .o_sel     (sel),
    .o_grant   (grant),
    .o_valid   (valid),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every new grant and every timeout pulse consumes one expectation.
  always @(negedge clk) begin
    int e;
    logic [15:0] oh;
    if (valid && !prev_valid) begin
      if (grant_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_grant: got sel %0d, expected no grant", sel);
      end else begin
        e  = grant_q.pop_front();
        oh = 16'd0;
        oh[e] = 1'b1;
        check("grant_sel", 32'(sel), 32'(e));
        check("grant_onehot", 32'(grant), 32'(oh));
      end
    end
    if (timeout) begin
      if (to_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_timeout: got pulse with sel %0d, expected none", sel);
      end else begin
        e = to_q.pop_front();
        check("timeout_sel", 32'(sel), 32'(e));
      end
    end
    prev_valid = valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;

    // Reset held two cycles with every requester active.
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    grant_q.push_back(0);
    rst = 1'b0;
    tick();
    check("first_grant_valid", 32'(valid), 32'h1);

    // Rotation 0..15,0 with done one cycle after each grant.
    for (int i = 0; i < 16; i++) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rot_gap", 32'(valid), 32'h0);
      grant_q.push_back((i + 1) % 16);
      tick();
    end

    // Wrap and skip: serve 13 so ptr = 14, then req 0x0011 picks 0, then 4.
    req = 16'h2000;
    tick();
    grant_q.push_back(13);
    tick();
    done = 1'b1;
    req  = 16'h0011;
    tick();
    done = 1'b0;
    grant_q.push_back(0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    grant_q.push_back(4);
    tick();

    // Timeout: requester 3 alone, never releases; hold limit 4.
    req = 16'h0008;
    grant_q.push_back(3);
    to_q.push_back(3);
    grant_q.push_back(3);
    tick();
    tick();
    cnt = 0;
    while (valid && cnt < 10) begin
      cnt++;
      tick();
    end
    check("hold_cycles", 32'(cnt), 32'd4);
    check("timeout_pulse", 32'(timeout), 32'h1);
    tick();
    check("timeout_one_cycle", 32'(timeout), 32'h0);
    check("regrant_valid", 32'(valid), 32'h1);

    // Owner 5 while req[9] toggles, then drop req[5] together with done.
    req = 16'h0020;
    grant_q.push_back(5);
    tick();
    tick();
    req = 16'h0220;
    tick();
    check("toggle_sel_a", 32'(sel), 32'd5);
    check("toggle_grant_a", 32'(grant), 32'h0020);
    req = 16'h0020;
    tick();
    check("toggle_sel_b", 32'(sel), 32'd5);
    check("toggle_valid_b", 32'(valid), 32'h1);
    req  = 16'h0200;
    done = 1'b1;
    tick();
    done = 1'b0;
    check("drop_done_valid", 32'(valid), 32'h0);
    check("drop_done_timeout", 32'(timeout), 32'h0);
    grant_q.push_back(9);
    tick();

    // Mid-grant reset with sel = 7; arbitration restarts from requester 0.
    req = 16'h0080;
    grant_q.push_back(7);
    tick();
    tick();
    check("pre_rst_sel", 32'(sel), 32'd7);
    rst = 1'b1;
    req = 16'hFFFF;
    tick();
    check("midrst_sel", 32'(sel), 32'h0);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_timeout", 32'(timeout), 32'h0);
    grant_q.push_back(0);
    rst = 1'b0;
    tick();
    tick();

    check("grant_q_drained", 32'(grant_q.size()), 32'd0);
    check("timeout_q_drained", 32'(to_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
